// File: rtl/shared_bus_pkg.sv
// Shared definitions for the shared-bus arbiter: FSM state encoding and
// the helper that sizes the owner index.
package shared_bus_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE       = 2'd0,
      GRANT      = 2'd1,
      TURNAROUND = 2'd2
   } state_t;

   // Owner index width; at least one bit even for a single requester.
   function automatic int owner_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/shared_bus_arbiter_rr_pick.sv
// Combinational circular priority picker: first set request at or after ptr,
// returned as one-hot, as an index, and as an any-request flag.
module rr_pick
   import shared_bus_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int OWNER_W = owner_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [OWNER_W-1:0] ptr,
   output logic [NUM_REQ-1:0] onehot,
   output logic [OWNER_W-1:0] idx,
   output logic               any
);

   // Walk the requesters starting at ptr and wrap; the first hit wins.
   always_comb begin
      int slot;
      slot   = 0;
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         slot = int'(ptr) + k;
         if (slot >= NUM_REQ) begin
            slot = slot - NUM_REQ;
         end
         if (!any && req[slot]) begin
            any          = 1'b1;
            onehot[slot] = 1'b1;
            idx          = OWNER_W'(slot);
         end
      end
   end

endmodule

// File: rtl/shared_bus_arbiter.sv
// Round-robin owner arbiter for a shared bidirectional net, with a dead
// turnaround between owners and an optional max-hold timeout.
module shared_bus_arbiter
   import shared_bus_pkg::*;
#(
   parameter  int NUM_REQ   = 2,
   parameter  int MAX_HOLD  = 16,
   parameter  int TA_CYCLES = 1,
   localparam int OWNER_W   = owner_width(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [NUM_REQ-1:0] oe,
   output logic [OWNER_W-1:0] owner,
   output logic               busy,
   output logic               timeout
);

   localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam int TA_W   = (TA_CYCLES <= 2) ? 1 : $clog2(TA_CYCLES);

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [OWNER_W-1:0] owner_q, owner_d;
   logic [OWNER_W-1:0] ptr_q, ptr_d, ptr_after;
   logic               busy_q, busy_d;
   logic               timeout_q, timeout_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [TA_W-1:0]    ta_q, ta_d;

   logic [NUM_REQ-1:0] pick_onehot;
   logic [OWNER_W-1:0] pick_idx;
   logic               pick_any;
   logic               others_req;
   logic               hold_at_max;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .OWNER_W (OWNER_W)
   ) u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   // Next-state and next-output logic; every register holds unless a rule fires.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      owner_d     = owner_q;
      ptr_d       = ptr_q;
      busy_d      = busy_q;
      timeout_d   = 1'b0;
      hold_d      = hold_q;
      ta_d        = ta_q;
      ptr_after   = '0;
      others_req  = (req & ~gnt_q) != '0;
      hold_at_max = (MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD));

      if (int'(owner_q) < NUM_REQ - 1) begin
         ptr_after = owner_q + OWNER_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d = GRANT;
               gnt_d   = pick_onehot;
               owner_d = pick_idx;
               busy_d  = 1'b1;
               hold_d  = (MAX_HOLD != 0) ? HOLD_W'(1) : '0;
            end
         end

         GRANT: begin
            // A voluntary release takes priority over a coincident timeout.
            if (!req[owner_q] || (hold_at_max && others_req)) begin
               state_d   = TURNAROUND;
               gnt_d     = '0;
               busy_d    = 1'b0;
               ptr_d     = ptr_after;
               ta_d      = '0;
               timeout_d = req[owner_q];
            end else if ((MAX_HOLD != 0) && (hold_q != HOLD_W'(MAX_HOLD))) begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end

         TURNAROUND: begin
            if (ta_q == TA_W'(TA_CYCLES - 1)) begin
               if (pick_any) begin
                  state_d = GRANT;
                  gnt_d   = pick_onehot;
                  owner_d = pick_idx;
                  busy_d  = 1'b1;
                  hold_d  = (MAX_HOLD != 0) ? HOLD_W'(1) : '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               ta_d = ta_q + TA_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         owner_q   <= '0;
         ptr_q     <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
         hold_q    <= '0;
         ta_q      <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
         hold_q    <= hold_d;
         ta_q      <= ta_d;
      end
   end

   assign gnt     = gnt_q;
   assign oe      = gnt_q;
   assign owner   = owner_q;
   assign busy    = busy_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Bench for shared_bus_arbiter: a 2-requester and a 4-requester instance
// checked every cycle against an owner/dead-time reference model.
module tb_shared_bus_arbiter;

   localparam int MAX_HOLD = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req_a;
   logic [3:0] req_b;

   logic [1:0] gnt_a, oe_a;
   logic [0:0] owner_a;
   logic       busy_a, timeout_a;
   logic [3:0] gnt_b, oe_b;
   logic [1:0] owner_b;
   logic       busy_b, timeout_b;

   int checks = 0;
   int errors = 0;

   // Reference model: current owner (-1 if none), remaining dead cycles,
   // round-robin start point, hold length and expected timeout pulse.
   int m_owner[2];
   int m_dead[2];
   int m_ptr[2];
   int m_hold[2];
   int m_tout[2];
   logic [3:0] prev_g[2];

   always #5 clk = ~clk;

   shared_bus_arbiter #(.NUM_REQ(2), .MAX_HOLD(MAX_HOLD), .TA_CYCLES(1)) dut_a (
      .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .oe(oe_a),
      .owner(owner_a), .busy(busy_a), .timeout(timeout_a)
   );

   shared_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(MAX_HOLD), .TA_CYCLES(2)) dut_b (
      .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .oe(oe_b),
      .owner(owner_b), .busy(busy_b), .timeout(timeout_b)
   );

   function automatic int nOf(input int d);
      return (d == 0) ? 2 : 4;
   endfunction

   function automatic int taOf(input int d);
      return (d == 0) ? 1 : 2;
   endfunction

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic releaseOwner(input int d);
      m_ptr[d]   = (m_owner[d] + 1) % nOf(d);
      m_owner[d] = -1;
      m_dead[d]  = taOf(d);
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic modelStep(input int d, input logic [3:0] r, input logic reset_now);
      int n;
      int idx;
      logic others;
      n = nOf(d);
      m_tout[d] = 0;
      if (reset_now) begin
         m_owner[d] = -1;
         m_dead[d]  = 0;
         m_ptr[d]   = 0;
         m_hold[d]  = 0;
      end else if (m_owner[d] >= 0) begin
         others = 1'b0;
         for (int i = 0; i < n; i++) begin
            if (i != m_owner[d] && r[i]) others = 1'b1;
         end
         if (!r[m_owner[d]]) begin
            releaseOwner(d);
         end else if (m_hold[d] == MAX_HOLD && others) begin
            releaseOwner(d);
            m_tout[d] = 1;
         end else if (m_hold[d] < MAX_HOLD) begin
            m_hold[d]++;
         end
      end else if (m_dead[d] > 1) begin
         m_dead[d]--;
      end else begin
         m_dead[d] = 0;
         for (int k = 0; k < n; k++) begin
            idx = (m_ptr[d] + k) % n;
            if (r[idx] && m_owner[d] < 0) begin
               m_owner[d] = idx;
               m_hold[d]  = 1;
            end
         end
      end
   endtask

   task automatic checkDut(input string name, input int d, input logic [3:0] g,
                           input logic [3:0] o, input logic [1:0] own,
                           input logic b, input logic t);
      logic [3:0] eg;
      eg = (m_owner[d] >= 0) ? 4'(1 << m_owner[d]) : 4'b0000;
      checkVal({name, "_gnt"}, 32'(g), 32'(eg));
      checkVal({name, "_oe_eq_gnt"}, 32'(o), 32'(g));
      checkVal({name, "_onehot"}, 32'($countones(g) <= 1), 32'd1);
      checkVal({name, "_busy"}, 32'(b), 32'(m_owner[d] >= 0));
      checkVal({name, "_timeout"}, 32'(t), 32'(m_tout[d]));
      if (m_owner[d] >= 0) begin
         checkVal({name, "_owner"}, 32'(own), 32'(m_owner[d]));
      end
      if (prev_g[d] != 4'b0000 && g != 4'b0000) begin
         checkVal({name, "_no_direct_switch"}, 32'(g), 32'(prev_g[d]));
      end
      prev_g[d] = g;
   endtask

   task automatic checkOutput();
      checkDut("a", 0, {2'b00, gnt_a}, {2'b00, oe_a}, {1'b0, owner_a}, busy_a, timeout_a);
      checkDut("b", 1, gnt_b, oe_b, owner_b, busy_b, timeout_b);
   endtask

   task automatic applyStimulus(input logic r, input logic [1:0] a, input logic [3:0] b);
      rst   = r;
      req_a = a;
      req_b = b;
   endtask

   task automatic tick();
      modelStep(0, {2'b00, req_a}, rst);
      modelStep(1, req_b, rst);
      @(posedge clk);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 2'b00, 4'h0);
      tick();
      tick();
   endtask

   initial begin
      int order[$];
      int expected_order[5];
      int waited;
      logic [3:0] rb;
      expected_order = '{0, 1, 2, 3, 0};
      for (int d = 0; d < 2; d++) begin
         m_owner[d] = -1; m_dead[d] = 0; m_ptr[d] = 0; m_hold[d] = 0; m_tout[d] = 0;
         prev_g[d] = 4'b0000;
      end

      // Reset with requests pending, then a single request.
      applyStimulus(1'b1, 2'b11, 4'hf);
      tick();
      tick();
      checkVal("t1_rst_gnt", 32'(gnt_a), 32'd0);
      checkVal("t1_rst_oe", 32'(oe_a), 32'd0);
      checkVal("t1_rst_owner", 32'(owner_a), 32'd0);
      checkVal("t1_rst_busy", 32'(busy_a), 32'd0);
      checkVal("t1_rst_timeout", 32'(timeout_a), 32'd0);
      applyStimulus(1'b0, 2'b01, 4'h0);
      tick();
      checkVal("t1_c1_gnt", 32'(gnt_a), 32'd1);
      checkVal("t1_c1_oe", 32'(oe_a), 32'd1);
      checkVal("t1_c1_busy", 32'(busy_a), 32'd1);

      // Voluntary release followed by one dead cycle and handover.
      doReset();
      applyStimulus(1'b0, 2'b11, 4'h0);
      tick();
      checkVal("t2_c1_gnt", 32'(gnt_a), 32'd1);
      tick();
      tick();
      applyStimulus(1'b0, 2'b10, 4'h0);
      tick();
      checkVal("t2_c4_gnt", 32'(gnt_a), 32'd0);
      tick();
      checkVal("t2_c5_gnt", 32'(gnt_a), 32'd2);
      checkVal("t2_c5_owner", 32'(owner_a), 32'd1);

      // Forced revocation after MAX_HOLD cycles with a competitor waiting.
      doReset();
      applyStimulus(1'b0, 2'b11, 4'h0);
      for (int c = 1; c <= 4; c++) begin
         tick();
         checkVal("t3_hold_gnt", 32'(gnt_a), 32'd1);
      end
      tick();
      checkVal("t3_c5_gnt", 32'(gnt_a), 32'd0);
      checkVal("t3_c5_timeout", 32'(timeout_a), 32'd1);
      tick();
      checkVal("t3_c6_gnt", 32'(gnt_a), 32'd2);
      checkVal("t3_c6_timeout", 32'(timeout_a), 32'd0);

      // Lone requester keeps the bus beyond MAX_HOLD.
      doReset();
      applyStimulus(1'b0, 2'b01, 4'h0);
      for (int c = 1; c <= 10; c++) begin
         tick();
         checkVal("t4_gnt", 32'(gnt_a), 32'd1);
         checkVal("t4_timeout", 32'(timeout_a), 32'd0);
      end

      // Reset during a grant to requester 1 restores the pointer to 0.
      doReset();
      applyStimulus(1'b0, 2'b11, 4'h0);
      tick();
      applyStimulus(1'b0, 2'b10, 4'h0);
      tick();
      tick();
      checkVal("t5_c3_gnt", 32'(gnt_a), 32'd2);
      applyStimulus(1'b1, 2'b11, 4'h0);
      tick();
      checkVal("t5_rst_gnt", 32'(gnt_a), 32'd0);
      checkVal("t5_rst_busy", 32'(busy_a), 32'd0);
      applyStimulus(1'b0, 2'b11, 4'h0);
      tick();
      checkVal("t5_after_gnt", 32'(gnt_a), 32'd1);

      // Four requesters, each dropping its request for one cycle once granted.
      doReset();
      applyStimulus(1'b0, 2'b00, 4'hf);
      for (int g = 0; g < 5; g++) begin
         waited = 0;
         while (gnt_b == 4'b0000 && waited < 12) begin
            tick();
            waited++;
         end
         checkVal("t6_grant_seen", 32'(gnt_b != 4'b0000), 32'd1);
         if (gnt_b != 4'b0000) begin
            order.push_back(int'(owner_b));
            rb = 4'hf;
            rb[owner_b] = 1'b0;
            applyStimulus(1'b0, 2'b00, rb);
            tick();
            applyStimulus(1'b0, 2'b00, 4'hf);
         end
      end
      for (int g = 0; g < order.size(); g++) begin
         checkVal("t6_order", 32'(order[g]), 32'(expected_order[g]));
      end

      // Randomised traffic with sticky requests and occasional resets.
      doReset();
      applyStimulus(1'b0, 2'b00, 4'h0);
      for (int c = 0; c < 800; c++) begin
         logic [1:0] na;
         logic [3:0] nb;
         na = req_a;
         nb = req_b;
         for (int i = 0; i < 2; i++) if ($urandom_range(0, 3) == 0) na[i] = ~na[i];
         for (int i = 0; i < 4; i++) if ($urandom_range(0, 3) == 0) nb[i] = ~nb[i];
         applyStimulus(($urandom_range(0, 99) == 0), na, nb);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
